// File: rtl/btle_rx_pdu_reader.sv
// btle_rx_pdu_reader
// Reads a CRC-good PDU (2 header octets plus payload) out of the multi-phase
// receiver's octet memory and streams it on a valid/ready byte interface.
// A 2-entry prefetch buffer hides the 1-cycle memory read latency. When the
// receiver signals that its memory is about to be rewritten, the frame is
// aborted.
module btle_rx_pdu_reader #(
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int HEADER_OCTETS  = 2,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hit_flag,
  input  logic                      decode_end,
  input  logic                      crc_ok,
  input  logic [2:0]                best_phase,
  input  logic [6:0]                payload_length,
  output logic [MEM_ADDR_WIDTH-1:0] pdu_octet_mem_addr,
  input  logic [7:0]                pdu_octet_mem_data,
  output logic [7:0]                m_octet,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_first,
  output logic                      m_last,
  output logic [2:0]                m_phase,
  output logic                      m_truncated,
  output logic                      frame_abort,
  output logic                      busy,
  output logic [COUNT_WIDTH-1:0]    pkt_count,
  output logic [COUNT_WIDTH-1:0]    drop_count
);

  // The index must be able to hold DEPTH itself, one past the last address.
  localparam int IDX_W = MEM_ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_add(
    input logic [COUNT_WIDTH-1:0] value,
    input logic [1:0]             inc
  );
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, value} + {{(COUNT_WIDTH-1){1'b0}}, inc};
    if (sum[COUNT_WIDTH]) begin
      return {COUNT_WIDTH{1'b1}};
    end else begin
      return sum[COUNT_WIDTH-1:0];
    end
  endfunction

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          fetch_idx_q, fetch_idx_d;
  logic [IDX_W-1:0]          total_q, total_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      inflight_q, inflight_d;
  logic                      infl_first_q, infl_first_d;
  logic                      infl_last_q, infl_last_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [7:0]                slot0_data_q, slot0_data_d;
  logic [7:0]                slot1_data_q, slot1_data_d;
  logic                      slot0_first_q, slot0_first_d;
  logic                      slot0_last_q, slot0_last_d;
  logic                      slot1_first_q, slot1_first_d;
  logic                      slot1_last_q, slot1_last_d;
  logic                      valid_q, valid_d;
  logic [2:0]                phase_q, phase_d;
  logic                      trunc_q, trunc_d;
  logic                      abort_q, abort_d;
  logic                      busy_q, busy_d;
  logic [COUNT_WIDTH-1:0]    pkt_q, pkt_d;
  logic [COUNT_WIDTH-1:0]    drop_q, drop_d;

  logic                      pop_s;
  logic [1:0]                level_s;
  logic [8:0]                total_sum_s;
  logic [IDX_W-1:0]          next_idx_s;
  logic                      pkt_inc_s;
  logic [1:0]                drop_inc_s;

  // Next-state logic: prefetch buffer, read issue, frame control and counters.
  always_comb begin
    state_d       = state_q;
    fetch_idx_d   = fetch_idx_q;
    total_d       = total_q;
    addr_d        = addr_q;
    infl_first_d  = infl_first_q;
    infl_last_d   = infl_last_q;
    slot0_data_d  = slot0_data_q;
    slot1_data_d  = slot1_data_q;
    slot0_first_d = slot0_first_q;
    slot0_last_d  = slot0_last_q;
    slot1_first_d = slot1_first_q;
    slot1_last_d  = slot1_last_q;
    phase_d       = phase_q;
    trunc_d       = trunc_q;
    abort_d       = 1'b0;
    pkt_inc_s     = 1'b0;
    drop_inc_s    = 2'd0;

    pop_s       = valid_q && m_ready;
    // Occupancy once this cycle's pop and the landing read are both applied;
    // issuing against this value keeps one octet per clock under full ready.
    level_s     = cnt_q - {1'b0, pop_s} + {1'b0, inflight_q};
    total_sum_s = {2'b00, payload_length} + 9'(HEADER_OCTETS);
    next_idx_s  = fetch_idx_q + IDX_W'(1);

    // Slot 0 is always the head; a landing read fills the first free slot.
    case ({pop_s, inflight_q})
      2'b01: begin
        if (cnt_q == 2'd0) begin
          slot0_data_d  = pdu_octet_mem_data;
          slot0_first_d = infl_first_q;
          slot0_last_d  = infl_last_q;
        end else begin
          slot1_data_d  = pdu_octet_mem_data;
          slot1_first_d = infl_first_q;
          slot1_last_d  = infl_last_q;
        end
      end
      2'b10: begin
        slot0_data_d  = slot1_data_q;
        slot0_first_d = slot1_first_q;
        slot0_last_d  = slot1_last_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_data_d  = pdu_octet_mem_data;
          slot0_first_d = infl_first_q;
          slot0_last_d  = infl_last_q;
        end else begin
          slot0_data_d  = slot1_data_q;
          slot0_first_d = slot1_first_q;
          slot0_last_d  = slot1_last_q;
          slot1_data_d  = pdu_octet_mem_data;
          slot1_first_d = infl_first_q;
          slot1_last_d  = infl_last_q;
        end
      end
      default: begin
        slot0_data_d = slot0_data_q;
      end
    endcase
    cnt_d      = level_s;
    inflight_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (decode_end && crc_ok) begin
          phase_d = best_phase;
          if (total_sum_s > 9'(DEPTH)) begin
            total_d = IDX_W'(DEPTH);
            trunc_d = 1'b1;
          end else begin
            total_d = total_sum_s[IDX_W-1:0];
            trunc_d = 1'b0;
          end
          fetch_idx_d = {IDX_W{1'b0}};
          addr_d      = {MEM_ADDR_WIDTH{1'b0}};
          state_d     = S_FETCH;
        end else if (decode_end) begin
          drop_inc_s = 2'd1;
        end else begin
          drop_inc_s = 2'd0;
        end
      end
      S_FETCH, S_DRAIN: begin
        if (hit_flag) begin
          // Memory is about to be overwritten: anything buffered or in flight is stale.
          cnt_d      = 2'd0;
          inflight_d = 1'b0;
          state_d    = S_IDLE;
          abort_d    = 1'b1;
          drop_inc_s = decode_end ? 2'd2 : 2'd1;
        end else begin
          drop_inc_s = decode_end ? 2'd1 : 2'd0;
          if (state_q == S_FETCH) begin
            if ((fetch_idx_q < total_q) && (level_s < 2'd2)) begin
              inflight_d   = 1'b1;
              infl_first_d = (fetch_idx_q == {IDX_W{1'b0}});
              infl_last_d  = (next_idx_s == total_q);
              fetch_idx_d  = next_idx_s;
              if (next_idx_s < total_q) begin
                addr_d  = next_idx_s[MEM_ADDR_WIDTH-1:0];
                state_d = S_FETCH;
              end else begin
                // Address parks on the final octet rather than running past it.
                addr_d  = addr_q;
                state_d = S_DRAIN;
              end
            end else begin
              fetch_idx_d = fetch_idx_q;
            end
          end else if (!valid_q && !inflight_q) begin
            state_d   = S_IDLE;
            pkt_inc_s = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        cnt_d      = 2'd0;
        inflight_d = 1'b0;
      end
    endcase

    valid_d = (cnt_d != 2'd0);
    busy_d  = (state_d != S_IDLE);
    pkt_d   = sat_add(pkt_q, {1'b0, pkt_inc_s});
    drop_d  = sat_add(drop_q, drop_inc_s);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fetch_idx_q   <= {IDX_W{1'b0}};
      total_q       <= {IDX_W{1'b0}};
      addr_q        <= {MEM_ADDR_WIDTH{1'b0}};
      inflight_q    <= 1'b0;
      infl_first_q  <= 1'b0;
      infl_last_q   <= 1'b0;
      cnt_q         <= 2'd0;
      slot0_data_q  <= 8'd0;
      slot1_data_q  <= 8'd0;
      slot0_first_q <= 1'b0;
      slot0_last_q  <= 1'b0;
      slot1_first_q <= 1'b0;
      slot1_last_q  <= 1'b0;
      valid_q       <= 1'b0;
      phase_q       <= 3'd0;
      trunc_q       <= 1'b0;
      abort_q       <= 1'b0;
      busy_q        <= 1'b0;
      pkt_q         <= {COUNT_WIDTH{1'b0}};
      drop_q        <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      fetch_idx_q   <= fetch_idx_d;
      total_q       <= total_d;
      addr_q        <= addr_d;
      inflight_q    <= inflight_d;
      infl_first_q  <= infl_first_d;
      infl_last_q   <= infl_last_d;
      cnt_q         <= cnt_d;
      slot0_data_q  <= slot0_data_d;
      slot1_data_q  <= slot1_data_d;
      slot0_first_q <= slot0_first_d;
      slot0_last_q  <= slot0_last_d;
      slot1_first_q <= slot1_first_d;
      slot1_last_q  <= slot1_last_d;
      valid_q       <= valid_d;
      phase_q       <= phase_d;
      trunc_q       <= trunc_d;
      abort_q       <= abort_d;
      busy_q        <= busy_d;
      pkt_q         <= pkt_d;
      drop_q        <= drop_d;
    end
  end

  assign pdu_octet_mem_addr = addr_q;
  assign m_octet            = slot0_data_q;
  assign m_valid            = valid_q;
  assign m_first            = slot0_first_q;
  assign m_last             = slot0_last_q;
  assign m_phase            = phase_q;
  assign m_truncated        = trunc_q;
  assign frame_abort        = abort_q;
  assign busy               = busy_q;
  assign pkt_count          = pkt_q;
  assign drop_count         = drop_q;

endmodule

// File: tb/tb_btle_rx_pdu_reader.sv
// Testbench for btle_rx_pdu_reader: directed frames against a queue-based
// reference model, plus hand-computed literal expectations.
module tb_btle_rx_pdu_reader;

  logic        clk;
  logic        rst;
  logic        hit_flag;
  logic        decode_end;
  logic        crc_ok;
  logic [2:0]  best_phase;
  logic [6:0]  payload_length;
  logic [5:0]  pdu_octet_mem_addr;
  logic [7:0]  pdu_octet_mem_data;
  logic [7:0]  m_octet;
  logic        m_valid;
  logic        m_ready;
  logic        m_first;
  logic        m_last;
  logic [2:0]  m_phase;
  logic        m_truncated;
  logic        frame_abort;
  logic        busy;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];

  typedef struct packed {
    logic [7:0] oct;
    logic       f;
    logic       l;
    logic [2:0] ph;
    logic       tr;
  } exp_t;

  exp_t exp_q[$];
  bit   chk_en      = 1'b0;
  bit   mdl_busy    = 1'b0;
  bit   fin_pending = 1'b0;
  bit   abort_next  = 1'b0;
  int   mdl_pkt     = 0;
  int   mdl_drop    = 0;
  int   mdl_total   = 0;
  bit   prev_stall  = 1'b0;
  logic [7:0] prev_oct;
  logic       prev_f;
  logic       prev_l;

  btle_rx_pdu_reader #(
    .MEM_ADDR_WIDTH(6),
    .HEADER_OCTETS (2),
    .COUNT_WIDTH   (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .hit_flag          (hit_flag),
    .decode_end        (decode_end),
    .crc_ok            (crc_ok),
    .best_phase        (best_phase),
    .payload_length    (payload_length),
    .pdu_octet_mem_addr(pdu_octet_mem_addr),
    .pdu_octet_mem_data(pdu_octet_mem_data),
    .m_octet           (m_octet),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_first           (m_first),
    .m_last            (m_last),
    .m_phase           (m_phase),
    .m_truncated       (m_truncated),
    .frame_abort       (frame_abort),
    .busy              (busy),
    .pkt_count         (pkt_count),
    .drop_count        (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Receiver memory: data appears one clock after its address is sampled.
  always @(posedge clk) pdu_octet_mem_data <= mem[pdu_octet_mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: checks this cycle's outputs, then applies this cycle's inputs.
  always @(negedge clk) begin : model
    exp_t e;
    bit   last_now;
    int   tot;
    last_now = 1'b0;
    if (chk_en) begin
      chk("m_busy", busy, mdl_busy);
      chk("m_pkt", pkt_count, mdl_pkt);
      chk("m_drop", drop_count, mdl_drop);
      chk("m_abort", frame_abort, abort_next);
      if (!mdl_busy || abort_next) chk("m_valid_idle", m_valid, 1'b0);
      if (prev_stall) begin
        chk("m_hold_valid", m_valid, 1'b1);
        chk("m_hold_octet", m_octet, prev_oct);
        chk("m_hold_first", m_first, prev_f);
        chk("m_hold_last", m_last, prev_l);
      end
      if (mdl_busy) chk("m_addr_range", (int'(pdu_octet_mem_addr) < mdl_total), 1'b1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("m_xfer_unexpected", m_octet, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("m_octet", m_octet, e.oct);
          chk("m_first", m_first, e.f);
          chk("m_last", m_last, e.l);
          chk("m_phase", m_phase, e.ph);
          chk("m_trunc", m_truncated, e.tr);
          last_now = e.l;
        end
      end
    end
    prev_stall = chk_en && m_valid && !m_ready;
    prev_oct   = m_octet;
    prev_f     = m_first;
    prev_l     = m_last;
    abort_next = 1'b0;
    if (rst) begin
      exp_q.delete();
      mdl_busy    = 1'b0;
      fin_pending = 1'b0;
      mdl_pkt     = 0;
      mdl_drop    = 0;
      mdl_total   = 0;
      prev_stall  = 1'b0;
    end else if (mdl_busy && hit_flag) begin
      exp_q.delete();
      mdl_busy    = 1'b0;
      fin_pending = 1'b0;
      mdl_drop    = mdl_drop + (decode_end ? 2 : 1);
      abort_next  = 1'b1;
      prev_stall  = 1'b0;
    end else begin
      if (decode_end) begin
        if (mdl_busy || !crc_ok) begin
          mdl_drop++;
        end else begin
          tot = int'(payload_length) + 2;
          e.tr = (tot > 64);
          if (tot > 64) tot = 64;
          mdl_total = tot;
          for (int i = 0; i < tot; i++) begin
            e.oct = mem[i];
            e.f   = (i == 0);
            e.l   = (i == tot - 1);
            e.ph  = best_phase;
            exp_q.push_back(e);
          end
          mdl_busy = 1'b1;
        end
      end
      // The frame completes one clock after its last octet is accepted.
      if (fin_pending) begin
        mdl_busy    = 1'b0;
        mdl_pkt++;
        fin_pending = 1'b0;
      end
      if (last_now) fin_pending = 1'b1;
    end
    if (mdl_drop > 65535) mdl_drop = 65535;
    if (mdl_pkt > 65535) mdl_pkt = 65535;
  end

  task automatic start(input logic [6:0] len, input logic [2:0] ph, input logic ok);
    decode_end     = 1'b1;
    crc_ok         = ok;
    payload_length = len;
    best_phase     = ph;
    tick();
    decode_end = 1'b0;
    crc_ok     = 1'b0;
  endtask

  initial begin
    logic [7:0] ev;
    int n;
    bit done;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 16);
    rst            = 1'b1;
    hit_flag       = 1'b0;
    decode_end     = 1'b0;
    crc_ok         = 1'b0;
    best_phase     = 3'd0;
    payload_length = 7'd0;
    m_ready        = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt", pkt_count, 16'd0);
    chk("rst_drop", drop_count, 16'd0);
    chk("rst_addr", pdu_octet_mem_addr, 6'd0);
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Frame of 7 octets at full ready: 0x10..0x16 from the second edge after start.
    m_ready = 1'b1;
    decode_end = 1'b1; crc_ok = 1'b1; payload_length = 7'd5; best_phase = 3'd5;
    @(negedge clk);
    chk("t1_valid_start", m_valid, 1'b0);
    tick();
    decode_end = 1'b0; crc_ok = 1'b0;
    @(negedge clk);
    chk("t1_busy_e0", busy, 1'b1);
    chk("t1_valid_e0", m_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_valid_e1", m_valid, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      @(negedge clk);
      ev = 8'h10 + 8'(i);
      chk("t1_valid", m_valid, 1'b1);
      chk("t1_octet", m_octet, ev);
      chk("t1_first", m_first, (i == 0));
      chk("t1_last", m_last, (i == 6));
      chk("t1_phase", m_phase, 3'd5);
    end
    tick();
    @(negedge clk);
    chk("t1_valid_after", m_valid, 1'b0);
    chk("t1_busy_drain", busy, 1'b1);
    tick();
    @(negedge clk);
    chk("t1_busy_done", busy, 1'b0);
    chk("t1_pkt", pkt_count, 16'd1);

    // Same frame with ready pattern 1,0,0,1.
    decode_end = 1'b1; crc_ok = 1'b1; payload_length = 7'd5; best_phase = 3'd2;
    for (int k = 0; k < 40; k++) begin
      m_ready = ((k % 4) == 0) || ((k % 4) == 3);
      tick();
      decode_end = 1'b0; crc_ok = 1'b0;
    end
    m_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_pkt", pkt_count, 16'd2);
    chk("t2_busy", busy, 1'b0);

    // Bad CRC: dropped, nothing streamed.
    start(7'd9, 3'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_valid", m_valid, 1'b0);
      chk("t3_busy", busy, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("t3_drop", drop_count, 16'd1);
    chk("t3_pkt", pkt_count, 16'd2);

    // Oversized payload clamps to 64 octets.
    start(7'd100, 3'd7, 1'b1);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        n++;
        if (m_last) begin
          chk("t4_last_octet", m_octet, 8'h4F);
          chk("t4_trunc", m_truncated, 1'b1);
          chk("t4_count", n, 64);
          done = 1'b1;
        end
      end
      tick();
    end
    chk("t4_done", done, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("t4_pkt", pkt_count, 16'd3);
    chk("t4_busy", busy, 1'b0);

    // Abort 4 clocks into a 20-octet frame under backpressure.
    m_ready = 1'b0;
    start(7'd18, 3'd1, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("t5_valid_pre", m_valid, 1'b1);
    chk("t5_octet_pre", m_octet, 8'h10);
    tick();
    hit_flag = 1'b1;
    tick();
    hit_flag = 1'b0;
    @(negedge clk);
    chk("t5_valid_abort", m_valid, 1'b0);
    chk("t5_abort", frame_abort, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_drop", drop_count, 16'd2);
    tick();
    @(negedge clk);
    chk("t5_abort_pulse", frame_abort, 1'b0);
    m_ready = 1'b1;
    start(7'd1, 3'd4, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    @(negedge clk);
    chk("t5_pkt", pkt_count, 16'd4);
    chk("t5_drop_after", drop_count, 16'd2);

    // Second decode_end mid-frame is dropped; first frame completes.
    start(7'd5, 3'd3, 1'b1);
    tick();
    decode_end = 1'b1; crc_ok = 1'b1; payload_length = 7'd9;
    tick();
    decode_end = 1'b0; crc_ok = 1'b0;
    @(negedge clk);
    chk("t6_drop", drop_count, 16'd3);
    for (int k = 0; k < 12; k++) tick();
    @(negedge clk);
    chk("t6_pkt", pkt_count, 16'd5);
    chk("t6_busy", busy, 1'b0);

    // Reset in the middle of a frame.
    m_ready = 1'b0;
    start(7'd20, 3'd6, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t7_valid", m_valid, 1'b0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_addr", pdu_octet_mem_addr, 6'd0);
    chk("t7_octet", m_octet, 8'd0);
    chk("t7_phase", m_phase, 3'd0);
    chk("t7_abort", frame_abort, 1'b0);
    chk("t7_pkt", pkt_count, 16'd0);
    chk("t7_drop", drop_count, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
